// File: rtl/ram_pkg.sv
// Shared constants and elaboration-time helpers for the RAM bank.
package ram_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_bank_if.sv
// Request/response channel between a requester (load/store unit or fetch)
// and a RAM bank. Both directions use valid/ready handshakes.
interface ram_bank_if
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [DATA_W/BYTE_W-1:0]   req_be;
  logic [ADDR_W-1:0]          req_addr;
  logic [DATA_W-1:0]          req_wdata;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic                       rsp_we;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );

endinterface

// File: rtl/ram_rsp_fifo.sv
// Synchronous FIFO holding completed responses until the consumer takes
// them. Push on a full FIFO and pop on an empty FIFO are ignored.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and fill count; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank with byte-addressed requests, byte write
// strobes, a 1- or 2-stage read pipeline and a credit-limited response queue.
module ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 65536,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  ram_bank_if.slave  bus
);

  localparam int NB     = DATA_W / BYTE_W;
  localparam int OFF_W  = clog2(NB);
  localparam int WIDX_W = ADDR_W - OFF_W;
  localparam int MEM_AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W  = clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              we;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [WIDX_W-1:0] widx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic              pop;

  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_d;

  logic              vld_p0;
  rsp_t              rsp_p0;
  logic              push;
  rsp_t              push_data;

  rsp_t              head;
  logic              fifo_empty;
  logic              unused_fifo_full;

  // Byte offset bits are dropped: misaligned addresses hit the containing word.
  assign widx     = WIDX_W'(bus.req_addr >> OFF_W);
  assign in_range = (64'(widx) < 64'(DEPTH));
  assign mem_idx  = MEM_AW'(widx);

  // A request is only counted when it is not killed by a same-edge reset.
  assign bus.req_ready = (occ_q < CNT_W'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready && !reset;
  assign wr_en         = accept && bus.req_we && in_range;

  // Byte-masked array write; out-of-range writes leave the array untouched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_be[b]) begin
          mem_q[mem_idx][b*BYTE_W +: BYTE_W] <= bus.req_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // ---- stage p0: array sampled on the accept edge ----
  // Build the response for the accepted request; writes and errors carry zero data.
  always_comb begin
    rsp_p0     = '0;
    rsp_p0.err = !in_range;
    rsp_p0.we  = bus.req_we;
    if (in_range && !bus.req_we) begin
      rsp_p0.rdata = mem_q[mem_idx];
    end
  end

  assign vld_p0 = accept;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign push      = vld_p0;
      assign push_data = rsp_p0;
    end else begin : g_lat2
      logic vld_p1_q;
      rsp_t rsp_p1_q;

      // ---- stage p1: extra register between array and response queue ----
      // Only the valid bit is reset; the payload follows it unconditionally.
      always_ff @(posedge clk) begin
        rsp_p1_q <= rsp_p0;
        if (reset) begin
          vld_p1_q <= 1'b0;
        end else begin
          vld_p1_q <= vld_p0;
        end
      end

      assign push      = vld_p1_q;
      assign push_data = rsp_p1_q;
    end
  endgenerate

  // ---- response queue: credits guarantee space when the pipeline delivers ----
  ram_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (unused_fifo_full),
    .empty_o     (fifo_empty)
  );

  // Output fields are forced to zero while the queue is empty so the idle
  // and post-reset response bus is clean without resetting queue storage.
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : '0;
  assign bus.rsp_err   = bus.rsp_valid && head.err;
  assign bus.rsp_we    = bus.rsp_valid && head.we;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // Occupancy next state: +1 on accept, -1 on response handshake.
  always_comb begin
    occ_d = occ_q;
    if (accept) begin
      occ_d = occ_d + CNT_W'(1);
    end
    if (pop) begin
      occ_d = occ_d - CNT_W'(1);
    end
  end

  // Occupancy register: requests in flight plus queued responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank with a 2-stage read pipeline and a 3-entry
// response queue.
module tb_ram_bank;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 1024;
  localparam int ADDR_W    = 32;
  localparam int READ_LAT  = 2;
  localparam int RSP_DEPTH = 3;
  localparam logic [31:0] OOR_ADDR = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   errs = 0;
  int   tb_occ = 0;

  logic [31:0] bp_addr [4];
  logic [31:0] model [16];
  logic [33:0] expq [$];

  ram_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .READ_LAT  (READ_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  // One request, then wait (bounded) for its response and check every field.
  task automatic xact(input string tag, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    n = 0;
    chk({tag, "_rdy"}, 64'(bus.req_ready), 64'(1));
    drive(we, be, addr, wd);
    step();
    idle();
    while (!bus.rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 64'(bus.rsp_valid), 64'(1));
    chk({tag, "_rd"},  64'(bus.rsp_rdata), 64'(exp_rd));
    chk({tag, "_err"}, 64'(bus.rsp_err),   64'(exp_err));
    chk({tag, "_we"},  64'(bus.rsp_we),    64'(we));
    step();
  endtask

  // Occupancy model from observed handshakes; req_ready must follow it.
  always @(negedge clk) begin
    #1;
    vec++;
    assert (bus.req_ready === (tb_occ < RSP_DEPTH)) else begin
      errs++;
      $error("FAIL occ_ready observed=%0b expected=%0b occ=%0d", bus.req_ready,
             (tb_occ < RSP_DEPTH), tb_occ);
    end
    if (reset) tb_occ = 0;
    else tb_occ = tb_occ + ((bus.req_valid && bus.req_ready) ? 1 : 0)
                         - ((bus.rsp_valid && bus.rsp_ready) ? 1 : 0);
    vec++;
    assert (tb_occ >= 0 && tb_occ <= RSP_DEPTH) else begin
      errs++;
      $error("FAIL occ_bound observed=%0d expected=0..%0d", tb_occ, RSP_DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    logic took;
    int stalls;
    int nrsp;
    int stale;
    logic we_s;
    logic [3:0] be_s;
    logic [31:0] addr_s;
    logic [31:0] wd_s;
    int widx;
    logic [33:0] exp_s;

    idle();
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    chk("rst_vld", 64'(bus.rsp_valid), 64'(0));
    chk("rst_err", 64'(bus.rsp_err),   64'(0));
    chk("rst_we",  64'(bus.rsp_we),    64'(0));
    chk("rst_rd",  64'(bus.rsp_rdata), 64'(0));
    chk("rst_rdy", 64'(bus.req_ready), 64'(1));
    reset = 1'b0;

    // Write then read back-to-back; exact latency of both responses.
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step();
    drive(1'b0, 4'h0, 32'h10, 32'h0);
    chk("lat_early", 64'(bus.rsp_valid), 64'(0));
    step();
    idle();
    chk("lat_w_vld", 64'(bus.rsp_valid), 64'(1));
    chk("lat_w_rd",  64'(bus.rsp_rdata), 64'(0));
    chk("lat_w_err", 64'(bus.rsp_err),   64'(0));
    chk("lat_w_we",  64'(bus.rsp_we),    64'(1));
    step();
    chk("lat_r_vld", 64'(bus.rsp_valid), 64'(1));
    chk("lat_r_rd",  64'(bus.rsp_rdata), 64'(32'hDEADBEEF));
    chk("lat_r_err", 64'(bus.rsp_err),   64'(0));
    chk("lat_r_we",  64'(bus.rsp_we),    64'(0));
    step();
    chk("lat_idle", 64'(bus.rsp_valid), 64'(0));

    // Partial byte write, read back through a misaligned address.
    xact("be5_wr", 1'b1, 4'h5, 32'h10, 32'h11223344, 32'h0, 1'b0);
    xact("be5_rd", 1'b0, 4'h0, 32'h13, 32'h0, 32'hDE22BE44, 1'b0);

    // Out-of-range accesses leave the array untouched.
    xact("pre_last", 1'b1, 4'hF, OOR_ADDR - 32'd4, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("pre_w0",   1'b1, 4'hF, 32'h0, 32'h01234567, 32'h0, 1'b0);
    xact("oor_rd",   1'b0, 4'h0, OOR_ADDR, 32'h0, 32'h0, 1'b1);
    xact("oor_wr",   1'b1, 4'hF, OOR_ADDR, 32'hFFFFFFFF, 32'h0, 1'b1);
    chk("bd_last", 64'(dut.mem_q[DEPTH-1]), 64'(32'hCAFEF00D));
    chk("bd_w0",   64'(dut.mem_q[0]),       64'(32'h01234567));
    xact("last_rd", 1'b0, 4'h0, OOR_ADDR - 32'd4, 32'h0, 32'hCAFEF00D, 1'b0);

    // be=0 write is a no-op that still answers.
    xact("be0_wr", 1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    xact("be0_rd", 1'b0, 4'h0, 32'h0, 32'h0, 32'h01234567, 1'b0);

    // Backpressure: only RSP_DEPTH reads accepted, then in-order drain.
    bp_addr[0] = 32'h10;
    bp_addr[1] = 32'h0;
    bp_addr[2] = OOR_ADDR - 32'd4;
    bp_addr[3] = 32'h10;
    bus.rsp_ready = 1'b0;
    acc_n = 0;
    drive(1'b0, 4'h0, bp_addr[0], 32'h0);
    for (int k = 0; k < 8; k++) begin
      took = bus.req_ready;
      step();
      if (took) begin
        acc_n++;
        bus.req_addr = bp_addr[acc_n];
      end
    end
    idle();
    chk("bp_acc",   64'(acc_n),         64'(RSP_DEPTH));
    chk("bp_rdy",   64'(bus.req_ready), 64'(0));
    chk("bp_vld",   64'(bus.rsp_valid), 64'(1));
    chk("bp_head",  64'(bus.rsp_rdata), 64'(32'hDE22BE44));
    step();
    chk("bp_hold",  64'(bus.rsp_rdata), 64'(32'hDE22BE44));
    chk("bp_hold_e", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_we}), 64'(3'b100));
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_d1_vld", 64'(bus.rsp_valid), 64'(1));
    chk("bp_d1",     64'(bus.rsp_rdata), 64'(32'h01234567));
    step();
    chk("bp_d2_vld", 64'(bus.rsp_valid), 64'(1));
    chk("bp_d2",     64'(bus.rsp_rdata), 64'(32'hCAFEF00D));
    step();
    chk("bp_empty",  64'(bus.rsp_valid), 64'(0));

    // Sustained stream of 100 mixed requests against a scoreboard.
    stalls = 0;
    nrsp = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rsp_valid) begin
        nrsp++;
        if (expq.size() == 0) chk("strm_q", 64'(bus.rsp_valid), 64'(0));
        else chk("strm", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_we}), 64'(expq.pop_front()));
      end
      if (!bus.req_ready) stalls++;
      we_s   = (k < 16) || (k % 3 == 1);
      widx   = (k < 16) ? k : (k * 7) % 16;
      addr_s = 32'h100 + 32'(widx * 4) + 32'(k % 4);
      if (k >= 16 && k % 17 == 5) addr_s = OOR_ADDR + 32'(k * 4);
      be_s   = (k < 16) ? 4'hF : 4'(k % 16);
      wd_s   = 32'h9E3779B9 * 32'(k + 1);
      if (addr_s >= OOR_ADDR) begin
        exp_s = {32'h0, 1'b1, we_s};
      end else if (we_s) begin
        for (int b = 0; b < 4; b++) begin
          if (be_s[b]) model[widx][b*8 +: 8] = wd_s[b*8 +: 8];
        end
        exp_s = {32'h0, 1'b0, 1'b1};
      end else begin
        exp_s = {model[widx], 1'b0, 1'b0};
      end
      expq.push_back(exp_s);
      drive(we_s, be_s, addr_s, wd_s);
      step();
    end
    idle();
    for (int k = 0; k < 10; k++) begin
      if (bus.rsp_valid) begin
        nrsp++;
        if (expq.size() == 0) chk("strm_q", 64'(bus.rsp_valid), 64'(0));
        else chk("strm", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_we}), 64'(expq.pop_front()));
      end
      step();
    end
    chk("strm_nrsp",   64'(nrsp),   64'(100));
    chk("strm_stalls", 64'(stalls), 64'(0));

    // Reset with two responses queued and one in flight.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 4'h0, 32'h10, 32'h0);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    drive(1'b0, 4'h0, OOR_ADDR - 32'd4, 32'h0);
    step();
    idle();
    chk("rr_pre_vld", 64'(bus.rsp_valid), 64'(1));
    chk("rr_pre_rdy", 64'(bus.req_ready), 64'(0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_vld", 64'(bus.rsp_valid), 64'(0));
    chk("rr_rdy", 64'(bus.req_ready), 64'(1));
    bus.rsp_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      step();
      if (bus.rsp_valid) stale++;
    end
    chk("rr_stale", 64'(stale), 64'(0));

    // A write presented on a reset edge must not reach the array.
    drive(1'b1, 4'hF, 32'h10, 32'hBAD0BAD0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk("rw_vld", 64'(bus.rsp_valid), 64'(0));
    xact("rw_rd", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDE22BE44, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
